// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit: HI/LO registers with multi-cycle MULT/DIV busy timing.
// Optional MULDIV_STALL_REQ_EN adds the combinational Stall_Req output for the hazard unit.
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] RS_Data,
  input  logic [31:0] RT_Data,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
`ifdef MULDIV_STALL_REQ_EN
  ,
  output logic        Stall_Req
`endif
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor_s, divisor_u, quot_s, rem_s, quot_u, rem_u;
  logic        div_zero, div_ovf, md_start;

  assign md_start = Start && (Op == OP_MULT || Op == OP_MULTU || Op == OP_DIV || Op == OP_DIVU);

  assign prod_s = $signed({{32{RS_Data[31]}}, RS_Data}) * $signed({{32{RT_Data[31]}}, RT_Data});
  assign prod_u = {32'd0, RS_Data} * {32'd0, RT_Data};

  // Divisors are sanitised so the divider never sees /0 or INT_MIN/-1; those cases are muxed below.
  assign div_zero  = (RT_Data == 32'd0);
  assign div_ovf   = (RS_Data == 32'h8000_0000) && (RT_Data == 32'hFFFF_FFFF);
  assign divisor_s = (div_zero || div_ovf) ? 32'd1 : RT_Data;
  assign divisor_u = div_zero ? 32'd1 : RT_Data;
  assign quot_s    = div_ovf ? 32'h8000_0000 : 32'($signed(RS_Data) / $signed(divisor_s));
  assign rem_s     = div_ovf ? 32'd0 : 32'($signed(RS_Data) % $signed(divisor_s));
  assign quot_u    = RS_Data / divisor_u;
  assign rem_u     = RS_Data % divisor_u;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_we_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_we_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = RUN;
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_we_d = !div_zero;
              cnt_d     = DIV_N;
              state_d   = RUN;
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quot_u;
              pend_we_d = !div_zero;
              cnt_d     = DIV_N;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = RS_Data;
            OP_MTLO: lo_d = RS_Data;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d   = IDLE;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

`ifdef MULDIV_STALL_REQ_EN
  assign Stall_Req = Busy | md_start;
`else
  logic unused_md_start;
  assign unused_md_start = md_start;
`endif

endmodule

// File: tb/tb_e_muldiv.sv
// Scoreboard bench for e_muldiv: expected HI/LO/busy-length pushed at issue, popped when Busy drops.
module tb_e_muldiv;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] RS_Data = 32'd0;
  logic [31:0] RT_Data = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;
`ifdef MULDIV_STALL_REQ_EN
  logic        Stall_Req;
`endif

  e_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .RS_Data(RS_Data),
    .RT_Data(RT_Data),
    .Busy(Busy),
    .HI(HI),
    .LO(LO)
`ifdef MULDIV_STALL_REQ_EN
    ,
    .Stall_Req(Stall_Req)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Caller is at a negedge; returns at the negedge after Busy has dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input bit poke, input string nm);
    exp_t e;
    int   cnt;
    e.hi = ehi; e.lo = elo; e.cyc = ecyc;
    sb.push_back(e);
    Start = 1'b1; Op = op; RS_Data = rs; RT_Data = rt;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 64) begin
      cnt++;
      if (poke && cnt == 1) begin
        Start = 1'b1; Op = 3'd6; RS_Data = 32'h0000_DEAD;
      end else begin
        Start = 1'b0; Op = 3'd0;
      end
      @(negedge Clk);
    end
    e = sb.pop_front();
    n_cmp++;
    if (cnt !== e.cyc) begin
      n_err++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, cnt, e.cyc);
    end
    n_cmp++;
    if (HI !== e.hi) begin
      n_err++;
      $display("FAIL %s HI got=%h exp=%h", nm, HI, e.hi);
    end
    n_cmp++;
    if (LO !== e.lo) begin
      n_err++;
      $display("FAIL %s LO got=%h exp=%h", nm, LO, e.lo);
    end
    $display("txn %-10s op=%0d rs=%h rt=%h busy=%0d HI=%h LO=%h", nm, op, rs, rt, cnt, HI, LO);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_held got=%b/%h/%h exp=0/0/0", Busy, HI, LO);
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_released got=%b/%h/%h exp=0/0/0", Busy, HI, LO);
    end
    $display("txn reset      Busy=%b HI=%h LO=%h", Busy, HI, LO);
  endtask

  task automatic test_mtx();
    issue(3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd0, 0, 1'b0, "mthi");
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, "mtlo");
  endtask

  task automatic test_mult();
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, "mult");
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, 1'b0, "multu");
  endtask

  task automatic test_div();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, "div");
    issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0, "divu");
  endtask

  task automatic test_div_edge();
    issue(3'd5, 32'hAAAA_0000, 32'd0, 32'hAAAA_0000, 32'd3, 0, 1'b0, "mthi_pre");
    issue(3'd6, 32'h0000_5555, 32'd0, 32'hAAAA_0000, 32'h0000_5555, 0, 1'b0, "mtlo_pre");
    issue(3'd3, 32'd123, 32'd0, 32'hAAAA_0000, 32'h0000_5555, 10, 1'b0, "div_zero");
    issue(3'd4, 32'd456, 32'd0, 32'hAAAA_0000, 32'h0000_5555, 10, 1'b0, "divu_zero");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, "div_ovf");
  endtask

  task automatic test_ignore_busy();
    // 7*9 = 63; the MTLO poked during RUN must not reach LO.
    issue(3'd1, 32'd7, 32'd9, 32'd0, 32'd63, 5, 1'b1, "mult_poke");
    issue(3'd7, 32'h1111_1111, 32'd0, 32'd0, 32'd63, 0, 1'b0, "reserved");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] p;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      issue(3'd2, a, b, p[63:32], p[31:0], 5, 1'b0, "b2b_multu");
      a = $urandom; b = 32'($urandom_range(1, 1000));
      issue(3'd4, a, b, a % b, a / b, 10, 1'b0, "b2b_divu");
    end
  endtask

  task automatic test_reset_midrun();
    issue(3'd5, 32'hCAFE_0001, 32'd0, 32'hCAFE_0001, LO, 0, 1'b0, "mthi_pre2");
    Start = 1'b1; Op = 3'd3; RS_Data = 32'd100; RT_Data = 32'd7;
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_midrun got=%b/%h/%h exp=0/0/0", Busy, HI, LO);
    end
    @(negedge Clk);
    Reset = 1'b1;
    repeat (15) @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_err++;
      $display("FAIL reset_no_late_update got=%b/%h/%h exp=0/0/0", Busy, HI, LO);
    end
    $display("txn reset_mid  Busy=%b HI=%h LO=%h", Busy, HI, LO);
  endtask

`ifdef MULDIV_STALL_REQ_EN
  task automatic test_stall_req();
    int cnt;
    Start = 1'b1; Op = 3'd1; RS_Data = 32'd2; RT_Data = 32'd3;
    #1;
    n_cmp++;
    if (Stall_Req !== 1'b1) begin
      n_err++;
      $display("FAIL stall_issue got=%b exp=1", Stall_Req);
    end
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    cnt = 0;
    while (Stall_Req === 1'b1 && cnt < 64) begin
      cnt++;
      @(negedge Clk);
    end
    n_cmp++;
    if (cnt !== 5) begin
      n_err++;
      $display("FAIL stall_len got=%0d exp=5", cnt);
    end
    Start = 1'b1; Op = 3'd5; RS_Data = 32'd1;
    #1;
    n_cmp++;
    if (Stall_Req !== 1'b0) begin
      n_err++;
      $display("FAIL stall_mthi got=%b exp=0", Stall_Req);
    end
    @(negedge Clk);
    Start = 1'b0; Op = 3'd0;
    $display("txn stall_req  len=%0d", cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_mtx();
    test_mult();
    test_div();
    test_div_edge();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midrun();
`ifdef MULDIV_STALL_REQ_EN
    test_stall_req();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
